demux_18_tdm: RTL and testbench
===============================

Name: demux_18_tdm

Overview:
- Receiving end of the 8:1 select path: takes a time-division sample stream and distributes it into 8 registered lanes.
- Lane order matches the 3-bit mux select encoding, so lane k carries the sample sent with select = k.
- Presents a complete 8-lane frame on a valid/ready output handshake.
- Sits downstream of the 8:1 mux tree / serial link, in front of per-channel consumers.

Parameters:
- WIDTH, 8, bits per sample / per lane.
- LANES, 8, number of output lanes; fixed at 8 (3-bit lane index); not to be overridden.

Ports:
- clk  input  1  sole clock; rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_data  input  WIDTH  incoming sample.
- in_valid  input  1  in_data valid this cycle.
- in_sync  input  1  qualifies in_valid; marks the first sample of a frame.
- in_ready  output  1  block accepts the sample this cycle.
- in_sel  input  3  explicit lane index; used only when EXPLICIT_SEL_EN is defined, ignored otherwise.
- out_data  output  8*WIDTH  lane k on bits [k*WIDTH +: WIDTH].
- out_strb  output  8  lane k written in the current frame.
- out_valid  output  1  complete frame held.
- out_ready  input  1  consumer takes the frame.
- frame_err  output  1  one-cycle pulse on a framing error.

Behaviour:
- Reset (async assert, sync release):
  - out_data = 0, out_strb = 0, out_valid = 0, frame_err = 0.
  - Lane counter cnt = 0, state = FILL.
  - in_ready is combinational; it is 1 in reset state.
- Accept: transfer occurs when in_valid && in_ready.
- in_ready = (state == FILL) || out_ready.
- States:
  - FILL: accepting samples.
    - Each transfer writes in_data to lane cnt, sets out_strb[cnt], and increments cnt.
    - A transfer with cnt = 7 moves to HOLD; out_valid = 1 the next cycle; cnt wraps to 0.
  - HOLD: out_valid = 1; out_data and out_strb are frozen.
    - out_ready = 1 and no transfer: out_valid -> 0, out_strb -> 0, state -> FILL.
    - out_ready = 1 with a simultaneous transfer: the frame is released and the sample is written to lane 0 the same edge. Next cycle out_strb = 8'h01, cnt = 1, state = FILL, out_valid = 0.
- Latency: 1 cycle from the 8th transfer to out_valid.
- Sync handling (FILL):
  - Transfer with in_sync = 1 and cnt != 0: the partial frame is discarded and frame_err pulses for 1 cycle. The sample is written to lane 0, out_strb = 8'h01, cnt = 1.
  - in_sync = 1 with cnt = 0: normal, no error.
  - in_sync on a sample other than the first is never required.
- out_data lanes not written in the current frame keep their old values. Consumers qualify lanes with out_strb.
- Reset mid-frame: partial frame dropped, all outputs return to reset values immediately.
- frame_err never asserts in reset state or in HOLD without a transfer.

Optional Feature:
- Macro: DEMUX_18_TDM_EXPLICIT_SEL_EN.
- Defined:
  - Write lane = in_sel and cnt is unused.
  - A frame completes (-> HOLD) when out_strb becomes 8'hFF.
  - A transfer to a lane whose strobe is already set overwrites the lane and pulses frame_err.
  - in_sync still clears out_strb and restarts the frame, with the same error rule when strb != 0.
- Undefined: in_sel ignored; sequential counter order as above.

Decomposition:
- Package demux_18_pkg:
  - LANES = 8, SEL_W = 3.
  - State enum {FILL, HOLD}.
  - Lane slice helper constant WIDTH-independent offsets.
- One sub-module: demux_lane_dec, a 3-to-8 one-hot decoder (lane index + enable -> 8-bit write enable). It mirrors the mux select tree and is reused for out_strb updates.

Test Plan:
- Reset then 8 transfers 8'h10..8'h17 with in_sync on the first, out_ready = 0 -> out_valid = 1 one cycle after the 8th. Lane k = 8'h10 + k, out_strb = 8'hFF, in_ready = 0.
- HOLD, then out_ready = 1 with in_valid = 1, data 8'hA0 -> frame released same edge; next cycle out_valid = 0, out_strb = 8'h01, lane0 = 8'hA0.
- 3 transfers, then a transfer with in_sync = 1, data 8'h55 -> frame_err pulses 1 cycle, out_strb = 8'h01, lane0 = 8'h55, and 7 more transfers are needed to complete.
- Back-to-back: in_valid held high 24 cycles, out_ready = 1 constant -> 3 frames, each out_valid for exactly 1 cycle, no stalls, frame_err never set.
- rst_n low after 5 transfers -> outputs 0 asynchronously; after release the first 8 transfers form a clean frame.
- EXPLICIT_SEL_EN: in_sel 7,0,3,3,1,2,4,5,6 -> frame_err on the second 3 (lane3 = later value). out_valid after the 6, out_strb = 8'hFF.

Source files
------------

// File: rtl/demux_18_pkg.sv
// Shared definitions for the demux_18_tdm slice: lane geometry, the
// FILL/HOLD state type and a helper that locates a lane inside the packed
// output word.
package demux_18_pkg;

    localparam int LANES = 8;
    localparam int SEL_W = 3;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_e;

    typedef logic [LANES-1:0] strb_t;

    localparam strb_t STRB_FULL = '1;

    // LSB position of lane 'lane' in a packed word of 'width'-bit lanes.
    function automatic int lane_lsb(input int lane, input int width);
        return lane * width;
    endfunction

endpackage

// File: rtl/demux_lane_dec.sv
// 3-to-8 one-hot lane decoder. Mirrors the upstream mux select tree: select
// value k enables lane k. Drives both the lane write enables and the strobe
// update in demux_18_tdm.
module demux_lane_dec
    import demux_18_pkg::*;
(
    input  logic [SEL_W-1:0] lane_idx,
    input  logic             en,
    output logic [LANES-1:0] lane_we
);

    // One-hot decode of the lane index, all zero when not enabled.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        lane_we = '0;
        if (en) begin
            lane_we[lane_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/demux_18_tdm.sv
// demux_18_tdm: distributes a time-division sample stream into 8 registered
// lanes and presents each complete frame on a valid/ready handshake.
// Optional feature: define DEMUX_18_TDM_EXPLICIT_SEL_EN to take the write
// lane from in_sel instead of an internal sequential lane counter.
module demux_18_tdm
    import demux_18_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [WIDTH-1:0]       in_data,
    input  logic                   in_valid,
    input  logic                   in_sync,
    output logic                   in_ready,
    input  logic [SEL_W-1:0]       in_sel,
    output logic [LANES*WIDTH-1:0] out_data,
    output logic [LANES-1:0]       out_strb,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   frame_err
);

    state_e                   state_q, state_d;
    logic [LANES*WIDTH-1:0]   out_data_q, out_data_d;
    strb_t                    out_strb_q, out_strb_d;
    logic                     frame_err_q, frame_err_d;

    logic                     xfer;
    logic [SEL_W-1:0]         wr_lane;
    logic [LANES-1:0]         lane_we;
    logic                     sync_restart;
    logic                     lane_dup;

    assign xfer = in_valid && in_ready;

`ifdef DEMUX_18_TDM_EXPLICIT_SEL_EN
    // Lane comes straight from the sender; a frame is done when every strobe is set.
    assign wr_lane      = in_sel;
    assign sync_restart = in_sync && (out_strb_q != '0);
    assign lane_dup     = |(out_strb_q & lane_we);
`else
    logic [SEL_W-1:0] cnt_q, cnt_d;
    logic             unused_sel;

    // A sync sample always lands in lane 0; otherwise the counter picks the lane.
    assign wr_lane      = in_sync ? '0 : cnt_q;
    assign sync_restart = in_sync && (cnt_q != '0);
    assign lane_dup     = 1'b0;
    assign unused_sel   = ^in_sel;
`endif

    demux_lane_dec u_lane_dec (
        .lane_idx (wr_lane),
        .en       (xfer),
        .lane_we  (lane_we)
    );

    // State, lane and strobe registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= FILL;
            // NOTE: the lane registers are visible outputs, so they take a reset value like any other output flop.
            out_data_q  <= '0;
            out_strb_q  <= '0;
            frame_err_q <= 1'b0;
`ifndef DEMUX_18_TDM_EXPLICIT_SEL_EN
            cnt_q       <= '0;
`endif
        end else begin
            // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
            state_q     <= state_d;
            out_data_q  <= out_data_d;
            out_strb_q  <= out_strb_d;
            frame_err_q <= frame_err_d;
`ifndef DEMUX_18_TDM_EXPLICIT_SEL_EN
            cnt_q       <= cnt_d;
`endif
        end
    end

    // Datapath: lane writes, strobe accumulation, restart and error detection.
    always_comb begin
        out_data_d  = out_data_q;
        out_strb_d  = out_strb_q;
        frame_err_d = 1'b0;
`ifndef DEMUX_18_TDM_EXPLICIT_SEL_EN
        cnt_d       = cnt_q;
`endif
        if (state_q == HOLD) begin
            // Release: the held frame is dropped and an accepted sample starts the next one.
            if (out_ready) begin
                out_strb_d = lane_we;
`ifndef DEMUX_18_TDM_EXPLICIT_SEL_EN
                cnt_d      = {{(SEL_W-1){1'b0}}, xfer};
`endif
            end
        end else if (xfer) begin
            out_strb_d  = (sync_restart ? '0 : out_strb_q) | lane_we;
            frame_err_d = sync_restart || lane_dup;
`ifndef DEMUX_18_TDM_EXPLICIT_SEL_EN
            cnt_d       = sync_restart ? SEL_W'(1) : cnt_q + SEL_W'(1);
`endif
        end
        for (int k = 0; k < LANES; k++) begin
            if (lane_we[k]) begin
                out_data_d[lane_lsb(k, WIDTH) +: WIDTH] = in_data;
            end
        end
    end

    // Next state: a transfer that fills the last strobe completes the frame.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            FILL: if (xfer && (out_strb_d == STRB_FULL)) state_d = HOLD;
            HOLD: if (out_ready) state_d = FILL;
        endcase
    end

    // Handshake outputs decoded from state.
    always_comb begin
        in_ready  = (state_q == FILL) || out_ready;
        out_valid = (state_q == HOLD);
    end

    assign out_data  = out_data_q;
    assign out_strb  = out_strb_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_demux_18_tdm.sv
// Self-checking bench for demux_18_tdm. A set-based reference model predicts
// every cycle; completed frames go into a scoreboard queue that a separate
// monitor drains when the DUT presents out_valid.
// Honors DEMUX_18_TDM_EXPLICIT_SEL_EN the same way as the RTL.
module tb_demux_18_tdm;

    localparam int WIDTH = 8;
    localparam int LANES = 8;

    logic                   clk;
    logic                   rst_n;
    logic [WIDTH-1:0]       in_data;
    logic                   in_valid;
    logic                   in_sync;
    logic                   in_ready;
    logic [2:0]             in_sel;
    logic [LANES*WIDTH-1:0] out_data;
    logic [LANES-1:0]       out_strb;
    logic                   out_valid;
    logic                   out_ready;
    logic                   frame_err;

    demux_18_tdm #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_sync   (in_sync),
        .in_ready  (in_ready),
        .in_sel    (in_sel),
        .out_data  (out_data),
        .out_strb  (out_strb),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .frame_err (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: lane contents, set of lanes written this frame,
    // whether a full frame is being held, and the expected error pulse.
    logic [WIDTH-1:0]       m_lane [LANES];
    logic [LANES-1:0]       m_strb;
    bit                     m_hold;
    bit                     m_err;
    logic [LANES*WIDTH-1:0] frame_q [$];
    bit                     mon_en;

    function automatic logic [LANES*WIDTH-1:0] pack_lanes();
        logic [LANES*WIDTH-1:0] p;
        for (int k = 0; k < LANES; k++) p[k*WIDTH +: WIDTH] = m_lane[k];
        return p;
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < LANES; k++) m_lane[k] = '0;
        m_strb = '0;
        m_hold = 1'b0;
        m_err  = 1'b0;
        frame_q.delete();
    endfunction

    // Accept one sample into the model.
    function automatic void model_accept(input logic [WIDTH-1:0] d, input bit s, input logic [2:0] sel);
        int lane;
        if (s && m_strb != '0) begin
            m_err  = 1'b1;
            m_strb = '0;
        end
`ifdef DEMUX_18_TDM_EXPLICIT_SEL_EN
        lane = int'(sel);
`else
        lane = $countones(m_strb);
`endif
        if (m_strb[lane]) m_err = 1'b1;
        m_lane[lane] = d;
        m_strb[lane] = 1'b1;
        if (m_strb == 8'hFF) begin
            m_hold = 1'b1;
            frame_q.push_back(pack_lanes());
        end
    endfunction

    // One clock cycle of stimulus; the model advances to the post-edge state.
    task automatic step(input bit v, input logic [WIDTH-1:0] d, input bit s,
                        input logic [2:0] sel, input bit rdy);
        bit exp_rdy;
        bit xfer;
        @(negedge clk);
        #1;
        in_valid  = v;
        in_data   = d;
        in_sync   = s;
        in_sel    = sel;
        out_ready = rdy;
        #1;
        exp_rdy = !m_hold || rdy;
        check("in_ready", 64'(in_ready), 64'(exp_rdy));
        xfer  = v && exp_rdy;
        m_err = 1'b0;
        if (m_hold && rdy) begin
            m_hold = 1'b0;
            m_strb = '0;
        end
        if (xfer) model_accept(d, s, sel);
    endtask

    task automatic idle(input bit rdy);
        step(1'b0, 8'h00, 1'b0, 3'd0, rdy);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        in_valid  = 1'b0;
        in_sync   = 1'b0;
        out_ready = 1'b0;
        rst_n     = 1'b0;
        #1;
        check("rst_out_data", out_data, 64'h0);
        check("rst_out_strb", 64'(out_strb), 64'h0);
        check("rst_out_valid", 64'(out_valid), 64'h0);
        check("rst_frame_err", 64'(frame_err), 64'h0);
        check("rst_in_ready", 64'(in_ready), 64'h1);
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Monitor: per-cycle outputs against the model, frames against the scoreboard.
    bit seen;
    always @(negedge clk) begin
        if (mon_en) begin
            logic [LANES*WIDTH-1:0] mask;
            for (int k = 0; k < LANES; k++) mask[k*WIDTH +: WIDTH] = {WIDTH{m_strb[k]}};
            check("out_valid", 64'(out_valid), 64'(m_hold));
            check("out_strb", 64'(out_strb), 64'(m_strb));
            check("frame_err", 64'(frame_err), 64'(m_err));
            check("lane_data", out_data & mask, pack_lanes() & mask);
            if (out_valid && !seen) begin
                seen = 1'b1;
                if (frame_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL frame_unexpected: got frame %h expected none at %0t", out_data, $time);
                end else begin
                    check("frame", out_data, frame_q.pop_front());
                end
            end
            if (!out_valid) seen = 1'b0;
        end
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_sync   = 1'b0;
        in_sel    = '0;
        out_ready = 1'b0;
        seen      = 1'b0;
        mon_en    = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        check("reset_in_ready", 64'(in_ready), 64'h1);
        check("reset_out_valid", 64'(out_valid), 64'h0);
        rst_n  = 1'b1;
        mon_en = 1'b1;

`ifdef DEMUX_18_TDM_EXPLICIT_SEL_EN
        begin
            logic [2:0] seq [9];
            seq = '{3'd7, 3'd0, 3'd3, 3'd3, 3'd1, 3'd2, 3'd4, 3'd5, 3'd6};
            for (int i = 0; i < 9; i++)
                step(1'b1, 8'hC0 + 8'(i), i == 0, seq[i], 1'b0);
            idle(1'b0);
            idle(1'b1);
        end
`endif

        // Full frame, held without a consumer.
        for (int k = 0; k < 8; k++) step(1'b1, 8'h10 + 8'(k), k == 0, 3'(k), 1'b0);
        idle(1'b0);
        idle(1'b0);
        // Release with a simultaneous transfer into lane 0.
        step(1'b1, 8'hA0, 1'b1, 3'd0, 1'b1);
        idle(1'b0);
        // Partial frame cut short by sync.
        step(1'b1, 8'h31, 1'b0, 3'd1, 1'b0);
        step(1'b1, 8'h32, 1'b0, 3'd2, 1'b0);
        step(1'b1, 8'h55, 1'b1, 3'd0, 1'b0);
        for (int k = 1; k < 8; k++) step(1'b1, 8'h60 + 8'(k), 1'b0, 3'(k), 1'b0);
        idle(1'b0);
        idle(1'b1);
        // Back-to-back streaming with a constant consumer.
        for (int i = 0; i < 24; i++) step(1'b1, 8'($urandom), (i % 8) == 0, 3'(i % 8), 1'b1);
        idle(1'b1);
        // Reset mid-frame, then a clean frame.
        for (int k = 0; k < 5; k++) step(1'b1, 8'h70 + 8'(k), k == 0, 3'(k), 1'b0);
        do_reset();
        for (int k = 0; k < 8; k++) step(1'b1, 8'h80 + 8'(k), k == 0, 3'(k), 1'b0);
        idle(1'b1);
        // Randomized traffic, including stray syncs.
        for (int i = 0; i < 800; i++)
            step($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 11) == 0,
                 3'($urandom_range(0, 7)), $urandom_range(0, 1) == 1);
        repeat (3) idle(1'b1);
        @(negedge clk);
        #1;
        check("frame_q_drained", 64'(frame_q.size()), 64'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
